// File: rtl/matmul_nxn_seq_if.sv
// matmul_nxn_seq_if: job, operand and result-handshake bundle for matmul_nxn_seq
// master drives start/acc_mode/clear/A/B/ready; slave drives C/valid/busy
interface matmul_nxn_seq_if #(
    parameter int BIT_PREC = 8,
    parameter int N        = 4,
    parameter int ACC_W    = 2*BIT_PREC + $clog2(N) + 4
);
    logic start;
    logic acc_mode;
    logic clear;
    logic ready;
    logic valid;
    logic busy;
    logic signed [BIT_PREC-1:0] A [N][N];
    logic signed [BIT_PREC-1:0] B [N][N];
    logic signed [ACC_W-1:0]    C [N][N];

    modport master (output start, acc_mode, clear, ready, A, B, input C, valid, busy);
    modport slave  (input start, acc_mode, clear, ready, A, B, output C, valid, busy);
endinterface

// File: rtl/matmul_nxn_seq.sv
// matmul_nxn_seq: sequential NxN signed matrix multiply(-accumulate), one k step of one row per cycle
// Ports: clk, rstn (async active-low), bus (slave): start/acc_mode/clear/A/B/ready in, C/valid/busy out
module matmul_nxn_seq #(
    parameter int BIT_PREC = 8,
    parameter int N        = 4,
    parameter int ACC_W    = 2*BIT_PREC + $clog2(N) + 4
) (
    input logic clk,
    input logic rstn,
    matmul_nxn_seq_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int PW = 2*BIT_PREC;
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    state_t state_q;
    logic valid_q;
    logic busy_q;
    logic mode_q;
    logic take;
    logic [CW-1:0] i_q;
    logic [CW-1:0] k_q;
    logic signed [BIT_PREC-1:0] a_q [N][N];
    logic signed [BIT_PREC-1:0] b_q [N][N];
    logic signed [ACC_W-1:0] c_q [N][N];
    logic signed [ACC_W-1:0] acc_q [N];
    logic signed [ACC_W-1:0] acc_d [N];
    logic [PW-1:0] a_x;
    logic [PW-1:0] prod [N];

    assign take = bus.start && (state_q == IDLE || (state_q == DONE && bus.ready));

    // Operands are sign-extended to PW bits first so the PW-bit product is the exact signed product.
    // At k=0 the running sum is seeded from the old C row (accumulate) or zero.
    always_comb begin
        a_x = {{BIT_PREC{a_q[i_q][k_q][BIT_PREC-1]}}, a_q[i_q][k_q]};
        for (int j = 0; j < N; j++) begin
            prod[j]  = a_x * {{BIT_PREC{b_q[k_q][j][BIT_PREC-1]}}, b_q[k_q][j]};
            acc_d[j] = (k_q != '0 ? acc_q[j] : (mode_q ? c_q[i_q][j] : '0))
                     + {{(ACC_W-PW){prod[j][PW-1]}}, prod[j]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '{default: '0};
            acc_q   <= '{default: '0};
        end else if (bus.clear) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            i_q     <= '0;
            k_q     <= '0;
            c_q     <= '{default: '0};
            acc_q   <= '{default: '0};
        end else if (take) begin
            state_q <= COMP;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            mode_q  <= bus.acc_mode;
            a_q     <= bus.A;
            b_q     <= bus.B;
            i_q     <= '0;
            k_q     <= '0;
        end else if (state_q == DONE && bus.ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else if (state_q == COMP) begin
            k_q <= (k_q == LAST) ? '0 : k_q + 1'b1;
            for (int j = 0; j < N; j++) begin
                if (k_q == LAST) c_q[i_q][j] <= acc_d[j];
                else acc_q[j] <= acc_d[j];
            end
            if (k_q == LAST) begin
                i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                if (i_q == LAST) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.C     = c_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_matmul_nxn_seq.sv
// tb_matmul_nxn_seq: directed and randomized checks of matmul_nxn_seq against a plain-arithmetic matrix model
module tb_matmul_nxn_seq;
    localparam int BP = 8;
    localparam int N  = 4;
    localparam int AW = 2*BP + $clog2(N) + 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int fails = 0;
    int ma [N][N];
    int mb [N][N];
    longint cm [N][N];

    matmul_nxn_seq_if #(.BIT_PREC(BP), .N(N), .ACC_W(AW)) bus ();

    matmul_nxn_seq #(.BIT_PREC(BP), .N(N), .ACC_W(AW)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic longint wrap(input longint v);
        longint r;
        r = v <<< (64 - AW);
        return r >>> (64 - AW);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s C[%0d][%0d]", tag, i, j), bus.C[i][j], cm[i][j]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                cm[i][j] = 0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = int'($urandom_range(0, 255)) - 128;
                mb[i][j] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_ops(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = av;
                mb[i][j] = bv;
            end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                bus.A[i][j] = BP'(ma[i][j]);
                bus.B[i][j] = BP'(mb[i][j]);
            end
    endtask

    // C := (mode ? C : 0) + A*B, reduced modulo 2^AW
    task automatic model_job(input bit mode);
        longint s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = mode ? cm[i][j] : 0;
                for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
                cm[i][j] = wrap(s);
            end
    endtask

    task automatic begin_job(input bit mode);
        drive_ops();
        bus.acc_mode = mode;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        model_job(mode);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        int bc = 0;
        while (!bus.valid && cyc < 100) begin
            if (bus.busy) bc++;
            step();
            cyc++;
        end
        check({tag, " latency"}, cyc, N*N);
        check({tag, " busy_cycles"}, bc, N*N);
        check_c(tag);
    endtask

    task automatic finish_job(input string tag, input int stall);
        wait_done(tag);
        for (int s = 0; s < stall; s++) begin
            step();
            check({tag, " stall_valid"}, bus.valid, 1);
        end
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check({tag, " post_valid"}, bus.valid, 0);
        check({tag, " post_busy"}, bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.acc_mode = 1'b0;
        bus.clear = 1'b0;
        bus.ready = 1'b0;
        fill_ops(0, 0);
        drive_ops();
        zero_model();
        #3;
        check("reset valid", bus.valid, 0);
        check("reset busy", bus.busy, 0);
        check_c("reset");
        rstn = 1'b1;

        // identity times B gives B; started on the first edge after reset release
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4*i + j;
            end
        begin_job(1'b0);
        check("ident busy", bus.busy, 1);
        finish_job("ident", 0);
        check("ident C[3][2]", bus.C[3][2], 14);

        // most negative operands, then accumulate on top
        fill_ops(-128, -128);
        begin_job(1'b0);
        finish_job("neg", 1);
        check("neg C[1][2]", bus.C[1][2], 65536);
        begin_job(1'b1);
        finish_job("negacc", 0);
        check("negacc C[3][0]", bus.C[3][0], 131072);

        // DONE stall with start pulses ignored, then back-to-back accept
        rand_ops();
        begin_job(1'b0);
        wait_done("stall");
        for (int s = 0; s < 5; s++) begin
            bus.start = (s == 1 || s == 3);
            bus.A[0][0] = BP'($urandom);
            step();
            check("stall valid", bus.valid, 1);
            check("stall busy", bus.busy, 0);
        end
        bus.start = 1'b0;
        check_c("stall hold");
        rand_ops();
        drive_ops();
        bus.acc_mode = 1'b1;
        bus.start = 1'b1;
        bus.ready = 1'b1;
        step();
        bus.start = 1'b0;
        bus.ready = 1'b0;
        check("b2b busy", bus.busy, 1);
        check("b2b valid", bus.valid, 0);
        model_job(1'b1);
        finish_job("b2b", 2);

        // async reset in COMP cycle 7
        rand_ops();
        begin_job(1'b0);
        repeat (6) step();
        rstn = 1'b0;
        #1;
        zero_model();
        check("rst valid", bus.valid, 0);
        check("rst busy", bus.busy, 0);
        check_c("rst");
        rstn = 1'b1;
        fill_ops(1, 1);
        begin_job(1'b1);
        finish_job("ones", 0);
        check("ones C[2][1]", bus.C[2][1], 4);

        // clear beats start in IDLE, and clear in DONE
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        zero_model();
        check("clr idle busy", bus.busy, 0);
        check("clr idle valid", bus.valid, 0);
        check_c("clr idle");
        step();
        check("clr idle stay", bus.busy, 0);
        rand_ops();
        begin_job(1'b0);
        wait_done("preclr");
        bus.clear = 1'b1;
        bus.ready = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.ready = 1'b0;
        zero_model();
        check("clr done valid", bus.valid, 0);
        check("clr done busy", bus.busy, 0);
        check_c("clr done");

        for (int n = 0; n < 200; n++) begin
            rand_ops();
            begin_job(1'($urandom_range(0, 1)));
            finish_job($sformatf("rnd%0d", n), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/matmul_nxn_seq.md
MATMUL_NXN_SEQ -- requirements
Module: matmul_nxn_seq

Interface
REQ-001 Parameter BIT_PREC, default 8, signed operand element width.
REQ-002 Parameter N, default 4, matrix dimension (N >= 2).
REQ-003 Parameter ACC_W, default 2*BIT_PREC+$clog2(N)+4, signed result element width, including accumulation guard bits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk and rstn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  job request; sampled only when accepted (see REQ-014).
REQ-008 acc_mode  input  1  sampled with an accepted start: 1 = C := C + A*B, 0 = C := A*B.
REQ-009 clear  input  1  synchronous abort and zeroing of results.
REQ-010 A, B  input  signed [BIT_PREC-1:0] [N][N]  operand matrices, sampled on start acceptance.
REQ-011 C  output  signed [ACC_W-1:0] [N][N]  registered result matrix.
REQ-012 valid / ready  output / input  1 / 1  result handshake.
REQ-013 busy  output  1  high while in COMP.

Function
REQ-014 States SHALL be IDLE, COMP and DONE; start is accepted in IDLE, or in DONE in the same cycle that ready=1.
REQ-015 On acceptance, A, B and acc_mode SHALL be registered, row counter i and k counter SHALL be set to 0, and the state SHALL go to COMP.
REQ-016 In COMP, each cycle SHALL perform one k step for row i using N parallel MACs: acc[j] += A[i][k]*B[k][j], with j = 0..N-1.
REQ-017 At k=0, acc[j] SHALL be initialised to C[i][j] when acc_mode=1, or to 0 when acc_mode=0, before the k=0 product is added.
REQ-018 At k=N-1, acc SHALL be written to C row i, k SHALL wrap to 0 and i SHALL increment.
REQ-019 At i=N-1 and k=N-1, the state SHALL go to DONE.
REQ-020 Latency: valid SHALL rise exactly N*N cycles after the accepting edge (16 for N=4).
REQ-021 Products SHALL be full signed 2*BIT_PREC products, sign-extended to ACC_W.
REQ-022 Sums SHALL wrap modulo 2^ACC_W, with no saturation.
REQ-023 In DONE, valid SHALL be 1, and C SHALL hold stable until valid && ready.
REQ-024 On valid && ready with no acceptable start, the state SHALL go to IDLE.
REQ-025 On valid && ready with start=1, the state SHALL go directly to COMP (back-to-back), with valid low the next cycle.
REQ-026 start SHALL be ignored in COMP, and in DONE while ready=0.
REQ-027 C rows SHALL update progressively during COMP; C is only guaranteed correct while valid=1.
REQ-028 clear=1 in any state SHALL, at the next edge, force IDLE, zero C and all accumulators, deassert valid, and reset counters.
REQ-029 clear SHALL take priority over start and over ready.
REQ-030 busy SHALL be 1 exactly in COMP; valid SHALL be 1 exactly in DONE.

Reset
REQ-031 rstn=0 SHALL immediately force state IDLE, valid=0, busy=0, C all zeros, i=k=0, and registered operands to 0, regardless of clk.
REQ-032 Reset asserted mid-COMP or mid-DONE SHALL discard the job; after release, the block SHALL accept a new start normally with no residual C contents.
REQ-033 The first edge after rstn release SHALL be able to accept start.

Verification
REQ-034 A = identity, B[r][c] = 4r+c, acc_mode=0, ready=1 -> valid 16 cycles after start, C = B, busy high for 16 cycles.
REQ-035 A and B all -128, acc_mode=0 -> every C element = 65536; then repeat with acc_mode=1 and the same operands -> every element = 131072.
REQ-036 ready=0 for 5 cycles after valid, with start pulsed during DONE -> valid held, C unchanged, start ignored; ready=1 with start=1 -> new job begins with no idle cycle.
REQ-037 rstn pulsed low at COMP cycle 7 -> C = 0 and valid = 0 asynchronously; a subsequent job with A = B = all 1 -> every C element = 4.
REQ-038 clear=1 together with start in IDLE, and clear=1 in DONE -> start not accepted, state IDLE, C zero, valid=0 next cycle.
REQ-039 Random signed A and B over 200 jobs, random ready stalls and random acc_mode -> C matches a reference model computing modulo 2^ACC_W.
